// File: rtl/rob_dispatch_if.sv
// Dispatch-side bus of the ROB allocator: a 2-lane instruction group in,
// registered ROB write strobes plus occupancy/stall status out.
interface rob_dispatch_if #(
   parameter int NUM_ROB_ENTS = 64
);
   localparam int IW = $clog2(NUM_ROB_ENTS);

   // Handshake: a group transfers on a cycle where in_valid != 0 and in_ready == 1.
   // in_valid is packed (lane1 only with lane0) and never waits on in_ready;
   // in_ready may look at in_valid. The group is taken whole or not at all.
   logic [1:0]    in_valid;
   logic [31:0]   in_pc0;
   logic [31:0]   in_pc1;
   logic [4:0]    in_rd0;
   logic [4:0]    in_rd1;
   logic [1:0]    in_rd_we;
   logic          in_ready;
   logic [1:0]    retire_cnt;
   logic          flush;

   logic [1:0]    rob_wr_en;
   logic [IW-1:0] rob_wr_idx0;
   logic [IW-1:0] rob_wr_idx1;
   logic [31:0]   rob_wr_pc0;
   logic [31:0]   rob_wr_pc1;
   logic [4:0]    rob_wr_rd0;
   logic [4:0]    rob_wr_rd1;
   logic [1:0]    rob_wr_rd_we;
   logic [IW:0]   occupancy;
   logic          rob_full;
   logic          rob_empty;
   logic [31:0]   stall_cycles;

   modport master (
      output in_valid, in_pc0, in_pc1, in_rd0, in_rd1, in_rd_we, retire_cnt, flush,
      input  in_ready, rob_wr_en, rob_wr_idx0, rob_wr_idx1, rob_wr_pc0, rob_wr_pc1,
             rob_wr_rd0, rob_wr_rd1, rob_wr_rd_we, occupancy, rob_full, rob_empty,
             stall_cycles
   );

   modport slave (
      input  in_valid, in_pc0, in_pc1, in_rd0, in_rd1, in_rd_we, retire_cnt, flush,
      output in_ready, rob_wr_en, rob_wr_idx0, rob_wr_idx1, rob_wr_pc0, rob_wr_pc1,
             rob_wr_rd0, rob_wr_rd1, rob_wr_rd_we, occupancy, rob_full, rob_empty,
             stall_cycles
   );
endinterface

// File: rtl/rob_dispatch.sv
// ROB allocator for a 2-wide dispatch: hands out circular ROB tags, tracks
// occupancy against retirement and flush, and counts dispatch stall cycles.
module rob_dispatch #(
   parameter int NUM_ROB_ENTS   = 64,
   parameter int DISPATCH_WIDTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   rob_dispatch_if.slave  bus
);
   localparam int IW = $clog2(NUM_ROB_ENTS);
   localparam int OW = IW + 1;
   localparam logic [OW-1:0] ENTS = OW'(NUM_ROB_ENTS);

   logic [IW-1:0] head_q, head_d;
   logic [IW-1:0] tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [OW-1:0] free;
   logic [OW:0]   occ_sum;
   logic [1:0]    n_req;
   logic          in_ready;
   logic          accept;
   logic [31:0]   stall_q, stall_d;

   logic [1:0]    wr_en_q;
   logic [IW-1:0] wr_idx0_q, wr_idx1_q;
   logic [31:0]   wr_pc0_q, wr_pc1_q;
   logic [4:0]    wr_rd0_q, wr_rd1_q;
   logic [1:0]    wr_rd_we_q;

   // free comes from registered occupancy, so slots retired this cycle are
   // only offered to dispatch on the next one.
   always_comb begin
      n_req    = {1'b0, bus.in_valid[0]} + {1'b0, bus.in_valid[1]};
      free     = ENTS - occ_q;
      in_ready = !bus.flush && (free >= OW'(n_req));
      accept   = (bus.in_valid != 2'b00) && in_ready;
      occ_sum  = {1'b0, occ_q} + (accept ? (OW+1)'(n_req) : '0);
      if (occ_sum < (OW+1)'(bus.retire_cnt)) begin
         occ_d = '0;
      end else begin
         occ_d = OW'(occ_sum - (OW+1)'(bus.retire_cnt));
      end
      tail_d  = accept ? (tail_q + IW'(n_req)) : tail_q;
      head_d  = head_q + IW'(bus.retire_cnt);
      stall_d = stall_q;
      if ((bus.in_valid != 2'b00) && !in_ready && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         stall_q    <= '0;
         wr_en_q    <= '0;
         wr_idx0_q  <= '0;
         wr_idx1_q  <= '0;
         wr_pc0_q   <= '0;
         wr_pc1_q   <= '0;
         wr_rd0_q   <= '0;
         wr_rd1_q   <= '0;
         wr_rd_we_q <= '0;
      end else begin
         stall_q <= stall_d;
         if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            wr_en_q <= '0;
         end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            wr_en_q <= accept ? bus.in_valid : 2'b00;
            if (accept) begin
               wr_idx0_q  <= tail_q;
               wr_idx1_q  <= tail_q + IW'(1);
               wr_pc0_q   <= bus.in_pc0;
               wr_pc1_q   <= bus.in_pc1;
               wr_rd0_q   <= bus.in_rd0;
               wr_rd1_q   <= bus.in_rd1;
               wr_rd_we_q <= bus.in_rd_we;
            end
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.rob_wr_en    = wr_en_q;
   assign bus.rob_wr_idx0  = wr_idx0_q;
   assign bus.rob_wr_idx1  = wr_idx1_q;
   assign bus.rob_wr_pc0   = wr_pc0_q;
   assign bus.rob_wr_pc1   = wr_pc1_q;
   assign bus.rob_wr_rd0   = wr_rd0_q;
   assign bus.rob_wr_rd1   = wr_rd1_q;
   assign bus.rob_wr_rd_we = wr_rd_we_q;
   assign bus.occupancy    = occ_q;
   assign bus.rob_full     = (occ_q == ENTS);
   assign bus.rob_empty    = (occ_q == '0);
   assign bus.stall_cycles = stall_q;

   // Illegal stimulus: unpacked lanes, or retiring more than is allocated.
   a_width_fixed: assert property (@(posedge clk) DISPATCH_WIDTH == 2);
   a_packed_valid: assert property (@(posedge clk) disable iff (rst)
      bus.in_valid != 2'b10);
   a_retire_legal: assert property (@(posedge clk) disable iff (rst || bus.flush)
      (bus.retire_cnt != 2'd3) && (OW'(bus.retire_cnt) <= occ_q));
endmodule

// File: tb/tb_rob_dispatch.sv
// Directed bench for rob_dispatch: an integer-level model of the ROB pointers
// and a tag queue, checked every cycle, plus hand-computed scenario checks.
module tb_rob_dispatch;
   localparam int N = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rob_dispatch_if #(.NUM_ROB_ENTS(N)) bus ();

   rob_dispatch #(.NUM_ROB_ENTS(N), .DISPATCH_WIDTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int pc_ctr       = 0;
   bit mdl_live     = 1'b0;
   bit preset       = 1'b0;

   int          mdl_occ  = 0;
   int          mdl_tail = 0;
   logic [31:0] mdl_stall = '0;
   logic [1:0]  exp_en = '0;
   logic [5:0]  exp_idx0, exp_idx1;
   logic [31:0] exp_pc0, exp_pc1;
   logic [4:0]  exp_rd0, exp_rd1;
   logic [1:0]  exp_rd_we;
   logic [5:0]  exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: pointers as plain integers, advanced by the dispatch/retire rules.
   always @(posedge clk) begin
      int  n;
      bit  rdy;
      bit  acc;
      mdl_live = 1'b1;
      n   = $countones(bus.in_valid);
      rdy = !bus.flush && ((N - mdl_occ) >= n);
      acc = (n != 0) && rdy;
      if (rst) begin
         mdl_occ   = 0;
         mdl_tail  = 0;
         mdl_stall = '0;
         exp_en    = '0;
         exp_q.delete();
      end else begin
         if (preset) mdl_stall = 32'hFFFF_FFFD;
         else if (n != 0 && !rdy && mdl_stall != 32'hFFFF_FFFF) mdl_stall = mdl_stall + 1;
         if (bus.flush) begin
            mdl_occ  = 0;
            mdl_tail = 0;
            exp_en   = '0;
         end else begin
            exp_en = acc ? bus.in_valid : 2'b00;
            if (acc) begin
               exp_idx0  = 6'(mdl_tail);
               exp_idx1  = 6'((mdl_tail + 1) % N);
               exp_pc0   = bus.in_pc0;
               exp_pc1   = bus.in_pc1;
               exp_rd0   = bus.in_rd0;
               exp_rd1   = bus.in_rd1;
               exp_rd_we = bus.in_rd_we;
               exp_q.push_back(6'(mdl_tail));
               if (bus.in_valid[1]) exp_q.push_back(6'((mdl_tail + 1) % N));
               mdl_tail = (mdl_tail + n) % N;
               mdl_occ  = mdl_occ + n;
            end
            mdl_occ = mdl_occ - int'(bus.retire_cnt);
            if (mdl_occ < 0) mdl_occ = 0;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (mdl_live) begin
         logic exp_rdy;
         exp_rdy = !bus.flush && ((N - mdl_occ) >= $countones(bus.in_valid));
         chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("occupancy", 32'(bus.occupancy), 32'(mdl_occ));
         chk("rob_full", 32'(bus.rob_full), 32'(mdl_occ == N));
         chk("rob_empty", 32'(bus.rob_empty), 32'(mdl_occ == 0));
         chk("stall_cycles", bus.stall_cycles, mdl_stall);
         chk("rob_wr_en", 32'(bus.rob_wr_en), 32'(exp_en));
         if (exp_en[0]) begin
            chk("wr_idx0", 32'(bus.rob_wr_idx0), 32'(exp_idx0));
            chk("wr_pc0", bus.rob_wr_pc0, exp_pc0);
            chk("wr_rd0", 32'(bus.rob_wr_rd0), 32'(exp_rd0));
            chk("wr_rd_we", 32'(bus.rob_wr_rd_we), 32'(exp_rd_we));
         end
         if (exp_en[1]) begin
            chk("wr_idx1", 32'(bus.rob_wr_idx1), 32'(exp_idx1));
            chk("wr_pc1", bus.rob_wr_pc1, exp_pc1);
            chk("wr_rd1", 32'(bus.rob_wr_rd1), 32'(exp_rd1));
         end
         if (bus.rob_wr_en[0]) begin
            chk("tag_q_lane0_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("tag_q_lane0", 32'(bus.rob_wr_idx0), 32'(exp_q.pop_front()));
         end
         if (bus.rob_wr_en[1]) begin
            chk("tag_q_lane1_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("tag_q_lane1", 32'(bus.rob_wr_idx1), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic cyc(input logic [1:0] v, input logic [1:0] rc, input logic fl);
      bus.in_valid   = v;
      bus.retire_cnt = rc;
      bus.flush      = fl;
      bus.in_pc0     = 32'h1000 + 32'(pc_ctr) * 32'd8;
      bus.in_pc1     = 32'h1004 + 32'(pc_ctr) * 32'd8;
      bus.in_rd0     = 5'($urandom_range(0, 31));
      bus.in_rd1     = 5'($urandom_range(0, 31));
      bus.in_rd_we   = 2'($urandom_range(0, 3));
      pc_ctr++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = '0; bus.retire_cnt = '0; bus.flush = 1'b0;
      bus.in_pc0 = '0; bus.in_pc1 = '0; bus.in_rd0 = '0; bus.in_rd1 = '0; bus.in_rd_we = '0;

      // Reset state
      cyc(2'b00, 2'd0, 1'b0);
      cyc(2'b00, 2'd0, 1'b0);
      chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
      chk("rst_empty", 32'(bus.rob_empty), 32'd1);
      chk("rst_full", 32'(bus.rob_full), 32'd0);
      chk("rst_stall", bus.stall_cycles, 32'd0);
      chk("rst_wr_en", 32'(bus.rob_wr_en), 32'd0);
      chk("rst_wr_pc0", bus.rob_wr_pc0, 32'd0);
      rst = 1'b0;
      bus.in_valid = 2'b11;
      #1;
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

      // Fill: 32 two-wide groups -> tags 0..63, ROB full
      for (int i = 0; i < 32; i++) cyc(2'b11, 2'd0, 1'b0);
      chk("fill_occupancy", 32'(bus.occupancy), 32'd64);
      chk("fill_full", 32'(bus.rob_full), 32'd1);
      chk("fill_last_idx0", 32'(bus.rob_wr_idx0), 32'd62);
      chk("fill_last_idx1", 32'(bus.rob_wr_idx1), 32'd63);
      #1;
      chk("fill_ready", 32'(bus.in_ready), 32'd0);

      // One slot free takes a single; then a full ROB stalls a pair
      cyc(2'b00, 2'd1, 1'b0);
      cyc(2'b01, 2'd0, 1'b0);
      chk("single_idx0", 32'(bus.rob_wr_idx0), 32'd0);
      chk("single_occupancy", 32'(bus.occupancy), 32'd64);
      for (int i = 0; i < 3; i++) cyc(2'b11, 2'd0, 1'b0);
      chk("stall_count3", bus.stall_cycles, 32'd3);
      cyc(2'b00, 2'd0, 1'b1);
      chk("flush_empty", 32'(bus.rob_empty), 32'd1);

      // Tail to 63 at occupancy 63; retire in same cycle does not free slots
      for (int i = 0; i < 31; i++) cyc(2'b11, 2'd0, 1'b0);
      cyc(2'b01, 2'd0, 1'b0);
      chk("occ63", 32'(bus.occupancy), 32'd63);
      chk("idx62", 32'(bus.rob_wr_idx0), 32'd62);
      cyc(2'b11, 2'd2, 1'b0);
      chk("retire_same_cycle_occ", 32'(bus.occupancy), 32'd61);
      chk("retire_same_cycle_noacc", 32'(bus.rob_wr_en), 32'd0);
      chk("retire_same_cycle_stall", bus.stall_cycles, 32'd4);
      cyc(2'b11, 2'd0, 1'b0);
      chk("wrap_en", 32'(bus.rob_wr_en), 32'd3);
      chk("wrap_idx0", 32'(bus.rob_wr_idx0), 32'd63);
      chk("wrap_idx1", 32'(bus.rob_wr_idx1), 32'd0);
      cyc(2'b01, 2'd0, 1'b0);
      chk("wrap_new_tail", 32'(bus.rob_wr_idx0), 32'd1);

      // Flush at occupancy 20 with dispatch and retire present
      for (int i = 0; i < 22; i++) cyc(2'b00, 2'd2, 1'b0);
      chk("occ20", 32'(bus.occupancy), 32'd20);
      cyc(2'b11, 2'd2, 1'b1);
      chk("flush_occ", 32'(bus.occupancy), 32'd0);
      chk("flush_wr_en", 32'(bus.rob_wr_en), 32'd0);
      chk("flush_stall", bus.stall_cycles, 32'd5);
      cyc(2'b11, 2'd0, 1'b0);
      chk("post_flush_idx0", 32'(bus.rob_wr_idx0), 32'd0);
      chk("post_flush_idx1", 32'(bus.rob_wr_idx1), 32'd1);

      // Reset mid-stream drops the group presented with it
      rst = 1'b1;
      cyc(2'b11, 2'd0, 1'b0);
      chk("midrst_wr_en", 32'(bus.rob_wr_en), 32'd0);
      chk("midrst_occ", 32'(bus.occupancy), 32'd0);
      chk("midrst_stall", bus.stall_cycles, 32'd0);
      rst = 1'b0;

      // Mixed traffic against the model
      for (int i = 0; i < 80; i++) begin
         logic [1:0] v;
         int         rmax;
         case ($urandom_range(0, 2))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         rmax = (mdl_occ < 2) ? mdl_occ : 2;
         cyc(v, 2'($urandom_range(0, rmax)), 1'($urandom_range(0, 15) == 0));
      end

      // Stall counter saturation
      cyc(2'b00, 2'd0, 1'b1);
      for (int i = 0; i < 32; i++) cyc(2'b11, 2'd0, 1'b0);
      bus.in_valid = 2'b11;
      bus.retire_cnt = 2'd0;
      @(negedge clk);
      force dut.stall_d = 32'hFFFF_FFFD;
      preset = 1'b1;
      @(posedge clk);
      #1;
      release dut.stall_d;
      preset = 1'b0;
      chk("stall_preset", bus.stall_cycles, 32'hFFFF_FFFD);
      cyc(2'b11, 2'd0, 1'b0);
      chk("stall_fe", bus.stall_cycles, 32'hFFFF_FFFE);
      cyc(2'b11, 2'd0, 1'b0);
      cyc(2'b11, 2'd0, 1'b0);
      chk("stall_saturated", bus.stall_cycles, 32'hFFFF_FFFF);

      bus.in_valid = 2'b00;
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
